// File: rtl/core_run_ctrl_pkg.sv
// Shared types for the core run controller: FSM states, run outcome
// encoding and the tohost value that signals a passing program.
package core_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        EV_NONE    = 3'd0,
        EV_PASS    = 3'd1,
        EV_FAIL    = 3'd2,
        EV_HANG    = 3'd3,
        EV_TIMEOUT = 3'd4
    } event_e;

    localparam int unsigned TOHOST_PASS = 1;

    // tohost outranks hang, hang outranks timeout
    function automatic event_e pick_event(
        input logic tohost,
        input logic is_pass,
        input logic hang,
        input logic tmo
    );
        if (tohost) return is_pass ? EV_PASS : EV_FAIL;
        if (hang)   return EV_HANG;
        if (tmo)    return EV_TIMEOUT;
        return EV_NONE;
    endfunction

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Up-counter with synchronous clear and count enable that holds at
// all-ones instead of wrapping.
module run_ctrl_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Core run controller: sequences core reset, runs it, and reports the outcome.
// Define CORE_RUN_CTRL_TRACE_EN for simulation tracing and auto-$finish.
module core_run_ctrl #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                CNT_W       = 32,
    parameter int                RST_CYCLES  = 2,
    parameter int                MAX_CYCLES  = 1000,
    parameter int                STALL_LIMIT = 8,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h0000_0040
) (
    input  logic              clk,
    input  logic              rst,
    output logic              core_rst_n,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [ADDR_W-1:0] pc,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              hang,
    output logic              timeout,
    output logic [DATA_W-2:0] fail_code,
    output logic [CNT_W-1:0]  cycle_count
);

    import core_run_ctrl_pkg::*;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] STALL_LAST =
        CNT_W'(STALL_LIMIT > 0 ? STALL_LIMIT - 1 : 0);
    localparam logic [DATA_W-1:0] PASS_VAL = DATA_W'(TOHOST_PASS);

    state_e            state_q;
    logic              core_rst_n_q;
    logic              done_q;
    logic              pass_q;
    logic              fail_q;
    logic              hang_q;
    logic              timeout_q;
    logic [DATA_W-2:0] fail_code_q;
    logic [ADDR_W-1:0] prev_pc_q;

    logic [CNT_W-1:0]  rst_cnt;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [CNT_W-1:0]  stall_cnt;

    logic   in_reset;
    logic   in_run;
    logic   tohost;
    logic   stalled;
    logic   hang_hit;
    logic   tmo_hit;
    event_e evt;

    assign in_reset = (state_q == ST_RESET);
    assign in_run   = (state_q == ST_RUN);

    assign tohost = in_run && mem_we && (mem_addr == TOHOST_ADDR)
                    && (mem_wdata != '0);

    // a zero cycle count marks the first RUN cycle, which has no prior PC
    assign stalled = in_run && (cyc_cnt != '0) && (pc == prev_pc_q);

    assign hang_hit = (STALL_LIMIT != 0) && stalled
                      && (stall_cnt == STALL_LAST);
    assign tmo_hit  = in_run && (cyc_cnt == RUN_LAST);

    assign evt = pick_event(tohost, mem_wdata == PASS_VAL, hang_hit, tmo_hit);

    run_ctrl_sat_counter #(.W(CNT_W)) u_rst_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (!in_reset),
        .en_i  (in_reset),
        .q_o   (rst_cnt)
    );

    run_ctrl_sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (in_reset),
        .en_i  (in_run && (evt == EV_NONE)),
        .q_o   (cyc_cnt)
    );

    run_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (!stalled),
        .en_i  (stalled),
        .q_o   (stall_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RESET;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            hang_q       <= 1'b0;
            timeout_q    <= 1'b0;
            fail_code_q  <= '0;
            prev_pc_q    <= '0;
        end else begin
            unique case (state_q)
                ST_RESET: begin
                    if (rst_cnt == RST_LAST) begin
                        state_q      <= ST_RUN;
                        core_rst_n_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    prev_pc_q <= pc;
                    if (evt != EV_NONE) begin
                        state_q      <= ST_DONE;
                        core_rst_n_q <= 1'b0;
                        done_q       <= 1'b1;
                        pass_q       <= (evt == EV_PASS);
                        fail_q       <= (evt == EV_FAIL);
                        hang_q       <= (evt == EV_HANG);
                        timeout_q    <= (evt == EV_TIMEOUT);
                        if (evt == EV_FAIL) begin
                            fail_code_q <= mem_wdata[DATA_W-1:1];
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_RESET;
                end
            endcase
        end
    end

    assign core_rst_n  = core_rst_n_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign hang        = hang_q;
    assign timeout     = timeout_q;
    assign fail_code   = fail_code_q;
    assign cycle_count = cyc_cnt;

`ifdef CORE_RUN_CTRL_TRACE_EN
    logic       fin_arm_q;
    logic [1:0] fin_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fin_arm_q <= 1'b0;
            fin_cnt_q <= '0;
        end else begin
            if (tohost) begin
                $display("core_run_ctrl: tohost addr=%h data=%h cycle=%0d",
                         mem_addr, mem_wdata, cyc_cnt);
            end
            if (in_run && (evt != EV_NONE)) begin
                $display("core_run_ctrl: done status=%s cycle=%0d",
                         evt.name(), cyc_cnt);
                fin_arm_q <= 1'b1;
                fin_cnt_q <= '0;
            end else if (fin_arm_q) begin
                if (fin_cnt_q == 2'd1) begin
                    $finish;
                end
                fin_cnt_q <= fin_cnt_q + 2'd1;
            end
        end
    end
`else
    // status is observable on the output ports only
`endif

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: two instances with different parameters share
// stimulus; table vectors, directed corner sequences and a random run.
module tb_core_run_ctrl;

    typedef struct packed {
        logic        rn;
        logic        done;
        logic        pass;
        logic        fail;
        logic        hang;
        logic        tmo;
        logic [30:0] fc;
        logic [31:0] cc;
    } obs_t;

    typedef struct {
        int rstc;
        int maxc;
        int stall;
    } cfg_t;

    // edges: clock edges seen since rst released; code 1..4 = pass/fail/hang/timeout
    typedef struct {
        int          edges;
        bit          fin;
        int          code;
        logic [30:0] fc;
        int          fcyc;
        int          same;
        logic [31:0] lpc;
    } mdl_t;

    typedef struct {
        logic        rst;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] pc;
        logic        rn;
        logic        done;
        logic [3:0]  st;
        logic [30:0] fc;
        logic [31:0] cc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] pc = '0;

    logic        a_core_rst_n, a_done, a_pass, a_fail, a_hang, a_timeout;
    logic [30:0] a_fail_code;
    logic [31:0] a_cycle_count;
    logic        b_core_rst_n, b_done, b_pass, b_fail, b_hang, b_timeout;
    logic [30:0] b_fail_code;
    logic [31:0] b_cycle_count;

    obs_t obs_a;
    obs_t obs_b;

    int vectors = 0;
    int miscompares = 0;

    cfg_t ca;
    cfg_t cb;
    mdl_t ma;
    mdl_t mb;
    vec_t tbl[11];

    always #5 clk = ~clk;

    core_run_ctrl #(
        .ADDR_W(32), .DATA_W(32), .CNT_W(32), .RST_CYCLES(3),
        .MAX_CYCLES(40), .STALL_LIMIT(8), .TOHOST_ADDR(32'h40)
    ) u_a (
        .clk(clk), .rst(rst), .core_rst_n(a_core_rst_n),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .pc(pc), .done(a_done), .pass(a_pass), .fail(a_fail),
        .hang(a_hang), .timeout(a_timeout), .fail_code(a_fail_code),
        .cycle_count(a_cycle_count)
    );

    core_run_ctrl #(
        .ADDR_W(32), .DATA_W(32), .CNT_W(32), .RST_CYCLES(2),
        .MAX_CYCLES(50), .STALL_LIMIT(0), .TOHOST_ADDR(32'h40)
    ) u_b (
        .clk(clk), .rst(rst), .core_rst_n(b_core_rst_n),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .pc(pc), .done(b_done), .pass(b_pass), .fail(b_fail),
        .hang(b_hang), .timeout(b_timeout), .fail_code(b_fail_code),
        .cycle_count(b_cycle_count)
    );

    assign obs_a = {a_core_rst_n, a_done, a_pass, a_fail, a_hang,
                    a_timeout, a_fail_code, a_cycle_count};
    assign obs_b = {b_core_rst_n, b_done, b_pass, b_fail, b_hang,
                    b_timeout, b_fail_code, b_cycle_count};

    function automatic mdl_t m_reset();
        mdl_t m;
        m = '{default: 0};
        return m;
    endfunction

    function automatic mdl_t m_step(mdl_t m, cfg_t c, logic we,
                                    logic [31:0] addr, logic [31:0] wd,
                                    logic [31:0] p);
        int n;
        if (m.fin) return m;
        if (m.edges >= c.rstc) begin
            n = m.edges - c.rstc;
            m.same = (n > 0 && p == m.lpc) ? m.same + 1 : 0;
            m.lpc = p;
            if (we && addr == 32'h40 && wd != 0) begin
                m.fin = 1;
                m.code = (wd == 1) ? 1 : 2;
                if (wd != 1) m.fc = wd[31:1];
            end else if (c.stall > 0 && m.same >= c.stall) begin
                m.fin = 1;
                m.code = 3;
            end else if (n == c.maxc - 1) begin
                m.fin = 1;
                m.code = 4;
            end
            m.fcyc = n;
        end
        m.edges++;
        return m;
    endfunction

    function automatic obs_t m_out(mdl_t m, cfg_t c);
        obs_t o;
        bit run;
        run = !m.fin && (m.edges >= c.rstc);
        o = '0;
        o.rn = run;
        o.done = m.fin;
        o.pass = (m.code == 1);
        o.fail = (m.code == 2);
        o.hang = (m.code == 3);
        o.tmo = (m.code == 4);
        o.fc = m.fc;
        if (m.fin) o.cc = 32'(m.fcyc);
        else if (run) o.cc = 32'(m.edges - c.rstc);
        return o;
    endfunction

    task automatic cmp(string nm, obs_t act, obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        if (rst) begin
            ma = m_reset();
            mb = m_reset();
        end else begin
            ma = m_step(ma, ca, mem_we, mem_addr, mem_wdata, pc);
            mb = m_step(mb, cb, mem_we, mem_addr, mem_wdata, pc);
        end
        @(posedge clk);
        #1;
        cmp("model_A", obs_a, m_out(ma, ca));
        cmp("model_B", obs_b, m_out(mb, cb));
    endtask

    task automatic idle_bus();
        mem_we = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        cmp("async_rst_A", obs_a, '0);
        cmp("async_rst_B", obs_b, '0);
        idle_bus();
        cycle();
    endtask

    task automatic release_seq();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_seq_rn", a_core_rst_n, i == 2);
        end
        chk("first_run_cc", a_cycle_count, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ca = '{3, 40, 8};
        cb = '{2, 50, 0};
        ma = m_reset();
        mb = m_reset();

        tbl[0]  = '{1, 0, 32'h0,  32'h0, 32'h0,   0, 0, 4'b0000, 0, 0};
        tbl[1]  = '{0, 1, 32'h40, 32'h1, 32'h0,   0, 0, 4'b0000, 0, 0};
        tbl[2]  = '{0, 0, 32'h0,  32'h0, 32'h0,   0, 0, 4'b0000, 0, 0};
        tbl[3]  = '{0, 0, 32'h0,  32'h0, 32'h0,   1, 0, 4'b0000, 0, 0};
        tbl[4]  = '{0, 1, 32'h40, 32'h0, 32'h100, 1, 0, 4'b0000, 0, 1};
        tbl[5]  = '{0, 0, 32'h0,  32'h0, 32'h104, 1, 0, 4'b0000, 0, 2};
        tbl[6]  = '{0, 1, 32'h44, 32'h1, 32'h108, 1, 0, 4'b0000, 0, 3};
        tbl[7]  = '{0, 0, 32'h40, 32'h5, 32'h10c, 1, 0, 4'b0000, 0, 4};
        tbl[8]  = '{0, 1, 32'h40, 32'h7, 32'h110, 0, 1, 4'b0100, 3, 4};
        tbl[9]  = '{0, 1, 32'h40, 32'h1, 32'h114, 0, 1, 4'b0100, 3, 4};
        tbl[10] = '{0, 0, 32'h0,  32'h0, 32'h114, 0, 1, 4'b0100, 3, 4};

        #1;
        cmp("reset_A", obs_a, '0);
        cmp("reset_B", obs_b, '0);

        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rst;
            mem_we = tbl[i].we;
            mem_addr = tbl[i].addr;
            mem_wdata = tbl[i].wd;
            pc = tbl[i].pc;
            cycle();
            cmp($sformatf("tbl[%0d]", i), obs_a,
                {tbl[i].rn, tbl[i].done, tbl[i].st, tbl[i].fc, tbl[i].cc});
        end

        // pass at RUN cycle 10
        do_reset();
        release_seq();
        for (int k = 0; k < 10; k++) begin
            pc = 32'h200 + 32'(4 * k);
            cycle();
        end
        chk("pass_pre_cc", a_cycle_count, 10);
        mem_we = 1'b1;
        mem_addr = 32'h40;
        mem_wdata = 32'h1;
        pc = 32'h228;
        cycle();
        idle_bus();
        chk("pass_done", a_done, 1);
        chk("pass_pass", a_pass, 1);
        chk("pass_others", {a_fail, a_hang, a_timeout}, 0);
        chk("pass_rn", a_core_rst_n, 0);
        chk("pass_cc", a_cycle_count, 10);

        // hang on A, then timeout on B
        do_reset();
        release_seq();
        for (int k = 0; k < 40 && !a_done; k++) begin
            pc = (k < 5) ? 32'h300 + 32'(4 * k) : 32'h20;
            cycle();
        end
        chk("hang_hang", a_hang, 1);
        chk("hang_cc", a_cycle_count, 13);
        chk("hang_tmo", a_timeout, 0);
        for (int k = 0; k < 80 && !b_done; k++) cycle();
        chk("tmo_tmo", b_timeout, 1);
        chk("tmo_cc", b_cycle_count, 49);
        chk("tmo_hang", b_hang, 0);

        // tohost in the timeout cycle wins
        do_reset();
        release_seq();
        for (int k = 0; k < 80 && b_cycle_count != 49; k++) begin
            pc = pc + 32'd4;
            cycle();
        end
        mem_we = 1'b1;
        mem_addr = 32'h40;
        mem_wdata = 32'h1;
        cycle();
        idle_bus();
        chk("prio_pass", b_pass, 1);
        chk("prio_tmo", b_timeout, 0);
        chk("prio_cc", b_cycle_count, 49);

        // reset mid-run
        do_reset();
        release_seq();
        for (int k = 0; k < 40 && a_cycle_count != 20; k++) begin
            pc = pc + 32'd4;
            cycle();
        end
        chk("midrun_cc", a_cycle_count, 20);
        do_reset();
        release_seq();

        // random run against the model
        begin
            bit hold_bias;
            int sel;
            hold_bias = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                if (rst) begin
                    rst = ($urandom_range(0, 2) == 0);
                    hold_bias = ($urandom_range(0, 1) == 1);
                end else if ($urandom_range(0, 99) == 0 ||
                             (a_done && b_done && $urandom_range(0, 3) == 0)) begin
                    rst = 1'b1;
                end
                sel = int'($urandom_range(0, 99));
                if (sel < (hold_bias ? 10 : 60)) pc = pc + 32'd4;
                else if (sel < 97) pc = pc;
                else pc = $urandom & 32'hFFFC;
                mem_we = ($urandom_range(0, 3) == 0);
                mem_addr = ($urandom_range(0, 9) == 0) ? 32'h40
                                                        : ($urandom & 32'hFFC);
                sel = int'($urandom_range(0, 2));
                mem_wdata = (sel == 0) ? 32'h0 : (sel == 1) ? 32'h1 : $urandom;
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Parametrised run controller for the single-cycle core simulation and FPGA bring-up flow. Sequences core reset for a configurable number of cycles and runs the core. Watches the data-memory store bus and PC, then declares pass, fail, hang or timeout. Sits beside `Single_Cycle_Top`: drives its `rst` input and taps its data-memory write port and PC.

## Interface
- `ADDR_W`, 32, width of address and PC.
- `DATA_W`, 32, width of store data.
- `CNT_W`, 32, width of cycle counters.
- `RST_CYCLES`, 2, core reset hold length in cycles (≥1).
- `MAX_CYCLES`, 1000, RUN cycles before timeout (≥1).
- `STALL_LIMIT`, 8, consecutive unchanged-PC cycles declaring hang; 0 disables hang detection.
- `TOHOST_ADDR`, 32'h0000_0040, status mailbox address.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `core_rst_n`  out  1  active-low reset to core; registered.
- `mem_we`  in  1  core data-memory write enable.
- `mem_addr`  in  ADDR_W  core data-memory address.
- `mem_wdata`  in  DATA_W  core store data.
- `pc`  in  ADDR_W  core program counter.
- `done`  out  1  run finished (sticky).
- `pass`  out  1  tohost wrote 1.
- `fail`  out  1  tohost wrote other nonzero value.
- `hang`  out  1  PC stalled STALL_LIMIT cycles.
- `timeout`  out  1  MAX_CYCLES reached.
- `fail_code`  out  DATA_W-1  `mem_wdata[DATA_W-1:1]` of failing write.
- `cycle_count`  out  CNT_W  RUN cycles elapsed.

## Operation
- FSM states: RESET, RUN, DONE. `rst` forces RESET asynchronously.
- RESET: `core_rst_n`=0, reset counter increments per cycle. After RST_CYCLES cycles -> RUN.
- RUN: `core_rst_n`=1. `cycle_count` increments each cycle. Bus monitored.
  - Tohost event: `mem_we`=1, `mem_addr`==TOHOST_ADDR, `mem_wdata`!=0. Data 1 -> pass. Any other nonzero value -> fail, with `fail_code` latched. Writes of 0 ignored.
  - Hang event (STALL_LIMIT>0): `pc` equals previous-cycle `pc` for STALL_LIMIT consecutive cycles. Stall counter clears on any PC change. The first RUN cycle has no previous PC and does not count.
  - Timeout event: `cycle_count` reaches MAX_CYCLES-1 in a RUN cycle.
  - Event priority in the same cycle: tohost > hang > timeout. Exactly one status bit is set.
  - Any event -> DONE.
- DONE: `core_rst_n`=0, freezing the core. `done` and the status bit are held. `cycle_count` is frozen. Bus inputs are ignored. Only `rst` exits DONE.
- Counters saturate at all-ones; they never wrap.

## Timing
- Reset values: `core_rst_n`=0, `done`=`pass`=`fail`=`hang`=`timeout`=0, `fail_code`=0, `cycle_count`=0.
- After `rst` falls, `core_rst_n` rises at the RST_CYCLES-th rising edge.
- The first RUN cycle shows `cycle_count`=0.
- Status outputs are registered. They assert at the edge ending the triggering cycle. `core_rst_n` falls on the same edge.
- `rst` asserted mid-RUN or in DONE clears everything immediately, without waiting for an edge.
- Bus activity in RESET cycles is ignored.

## Configuration
- `CORE_RUN_CTRL_TRACE_EN` defined: simulation-only code is compiled in.
  - Each tohost write is `$display`ed with address, data and `cycle_count`.
  - On entering DONE, the status is printed, then `$finish` is called 2 cycles later.
- Undefined: no system tasks are compiled in. The block is fully synthesizable, and the status stays visible on outputs only.

## Structure
- `core_run_ctrl_pkg`:
  - state enum (RESET, RUN, DONE).
  - status encoding constants.
  - the tohost pass value (1).
- Sub-module `run_ctrl_sat_counter`: parametrised saturating counter with clear and enable. Instantiated for the reset count, `cycle_count` and the stall count.

## Test plan
- Reset sequencing: RST_CYCLES=3; `rst` pulsed then low -> `core_rst_n` rises at the 3rd edge, and `cycle_count`=0 in the first RUN cycle.
- Pass: store of 1 to 0x40 at RUN cycle 10 -> next edge `done`=`pass`=1, `cycle_count`=10, `core_rst_n`=0, other status bits 0.
- Fail: store of 0x0000_0007 to 0x40 -> `fail`=1, `fail_code`=3. A store of 0 to 0x40 earlier has no effect.
- Hang/timeout: with STALL_LIMIT=8, PC held at 0x20 from cycle 5 -> `hang`=1 after 8 stalled cycles. With STALL_LIMIT=0 and MAX_CYCLES=50 -> `timeout`=1 with `cycle_count`=49.
- Priority: tohost write of 1 in the same cycle the timeout fires -> `pass`=1, `timeout`=0.
- Reset mid-run: `rst` asserted at RUN cycle 20, held 1 cycle -> all outputs 0 immediately, and the full RESET sequence repeats.
